// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier, 6x6 signed -> 12-bit signed, six steps per operation.
// Optional macro BOOTH_DONE_STICKY_EN: done holds until the next start edge instead of pulsing.
module booth_seq_mult (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  multiplicand,
    input  logic [5:0]  multiplier,
    output logic [11:0] product,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        start_dly_q;
    logic [6:0]  a_q, a_d;
    logic [5:0]  m_q, m_d;
    logic [5:0]  qr_q, qr_d;
    logic        q1_q, q1_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] product_q, product_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        start_edge_s;
    logic [13:0] step_s;

    // One Booth step on {A,Qr,Q_1}: add/subtract sign-extended M into the 7-bit A, then arithmetic shift right.
    function automatic logic [13:0] booth_step(input logic [6:0] a, input logic [5:0] m,
                                               input logic [5:0] qr, input logic q1);
        logic [6:0] sum;
        case ({qr[0], q1})
            2'b01:   sum = a + {m[5], m};
            2'b10:   sum = a - {m[5], m};
            default: sum = a;
        endcase
        return {sum[6], sum, qr};
    endfunction

    assign start_edge_s = start & ~start_dly_q;
    assign step_s       = booth_step(a_q, m_q, qr_q, q1_q);

    // Next-state logic for the FSM, datapath and registered outputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        m_d       = m_q;
        qr_d      = qr_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge_s) begin
                    m_d     = multiplicand;
                    a_d     = 7'd0;
                    qr_d    = multiplier;
                    q1_d    = 1'b0;
                    cnt_d   = 3'd0;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                a_d  = step_s[13:7];
                qr_d = step_s[6:1];
                q1_d = step_s[0];
                if (cnt_q == 3'd5) begin
                    // Low 12 bits of the shifted {A,Qr}; the top A bit is only a guard bit.
                    product_d = step_s[12:1];
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DONE: begin
`ifdef BOOTH_DONE_STICKY_EN
                if (start_edge_s) begin
                    m_d     = multiplicand;
                    a_d     = 7'd0;
                    qr_d    = multiplier;
                    q1_d    = 1'b0;
                    cnt_d   = 3'd0;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_CALC);
`ifdef BOOTH_DONE_STICKY_EN
        done_d = (state_q == ST_DONE) & ~start_edge_s;
`else
        done_d = (state_q == ST_DONE);
`endif
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            start_dly_q <= 1'b0;
            a_q         <= 7'd0;
            m_q         <= 6'd0;
            qr_q        <= 6'd0;
            q1_q        <= 1'b0;
            cnt_q       <= 3'd0;
            product_q   <= 12'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_dly_q <= start;
            a_q         <= a_d;
            m_q         <= m_d;
            qr_q        <= qr_d;
            q1_q        <= q1_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
